udp_ip_tx_gen: RTL

Multi-channel UDP/IPv4 datagram generator. It arbitrates N byte-wide AXIS payload sources and prepends a computed 20-byte IPv4 header and an 8-byte UDP header to each payload, with a per-frame runtime length. The block enforces the declared length by padding or truncating, then inserts an inter-frame gap. Its output feeds eth_framer directly.

---
 rtl/udp_ip_tx_gen.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/udp_ip_tx_gen.sv
// Multi-channel UDP/IPv4 datagram generator: round-robin payload arbitration,
// 28-byte IPv4+UDP header, length pad/truncate, inter-frame gap. Option: PKT_STATS_EN.
module udp_ip_tx_gen #(
    parameter int unsigned NUM_CHANNELS  = 2,
    parameter int unsigned MAX_PAYLOAD   = 1472,
    parameter int unsigned GAP_CYCLES    = 12,
    parameter logic [31:0] SRC_IP        = 32'hC0A80001,
    parameter logic [31:0] DST_IP        = 32'hC0A80002,
    parameter logic [15:0] SRC_PORT_BASE = 16'd100
) (
    input  logic                       clk,
    input  logic                       areset,
    output logic [NUM_CHANNELS-1:0]    s_axis_tready,
    input  logic [NUM_CHANNELS-1:0]    s_axis_tvalid,
    input  logic [NUM_CHANNELS-1:0]    s_axis_tlast,
    input  logic [8*NUM_CHANNELS-1:0]  s_axis_tdata,
    input  logic [16*NUM_CHANNELS-1:0] s_len,
    input  logic [16*NUM_CHANNELS-1:0] s_dest_port,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    output logic [7:0]                 m_axis_tdata,
    output logic                       err_pad,
    output logic                       err_trunc
`ifdef PKT_STATS_EN
    ,
    output logic [31:0]                stat_frames,
    output logic [15:0]                stat_pad,
    output logic [15:0]                stat_trunc
`endif
);

    localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1) + 1;

    typedef enum logic [2:0] {IDLE, CALC, HDR, PAY, PAD, DRAIN, GAP} state_t;
    state_t state, state_n;

    logic [CW-1:0]  rr_ptr, grant, grant_idx, grant_ptr_n, cand;
    logic           grant_found;
    logic [15:0]    len_q, dport_q, ip_id, csum, cnt;
    logic [15:0]    tot_len, udp_len, sport, fold2;
    logic [16:0]    fold1;
    logic [31:0]    sum;
    logic [4:0]     hdr_idx;
    logic [GW-1:0]  gap_cnt;
    logic [223:0]   hdr_vec;
    logic           out_accept, in_fire, last_hs, byte_is_last, gap_done;
    logic           load, load_last, pad_ev, trunc_ev;
    logic [7:0]     load_data;

    function automatic logic [15:0] clamp_len(input logic [15:0] l);
        if (l == 16'd0) return 16'd1;
        if (32'(l) > MAX_PAYLOAD) return 16'(MAX_PAYLOAD);
        return l;
    endfunction

    assign out_accept   = !m_axis_tvalid || m_axis_tready;
    assign last_hs      = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign in_fire      = s_axis_tvalid[grant] && out_accept;
    assign byte_is_last = (cnt + 16'd1 == len_q);
    assign gap_done     = (32'(gap_cnt) + 32'd1 >= 32'(GAP_CYCLES));

    assign tot_len = len_q + 16'd28;
    assign udp_len = len_q + 16'd8;
    assign sport   = SRC_PORT_BASE + 16'(grant);
    assign hdr_vec = {16'h4500, tot_len, ip_id, 16'h4000, 8'h40, 8'h11, csum,
                      SRC_IP, DST_IP, sport, dport_q, udp_len, 16'h0000};

    // Checksum field is zero during the sum, so it is simply left out.
    assign sum = 32'h4500 + 32'(tot_len) + 32'(ip_id) + 32'h4000 + 32'h4011
               + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0])
               + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
    assign fold1 = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
    assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            cand = CW'((32'(rr_ptr) + i) % NUM_CHANNELS);
            if (!grant_found && s_axis_tvalid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_ptr_n = (grant_idx == CW'(NUM_CHANNELS - 1)) ? '0 : grant_idx + CW'(1);
    end

    always_comb begin
        state_n       = state;
        load          = 1'b0;
        load_data     = '0;
        load_last     = 1'b0;
        pad_ev        = 1'b0;
        trunc_ev      = 1'b0;
        s_axis_tready = '0;
        case (state)
            IDLE: if (grant_found) state_n = CALC;
            CALC: begin
                // First header byte needs no checksum, so it goes out while the sum is latched.
                if (out_accept) begin
                    load      = 1'b1;
                    load_data = hdr_vec[223:216];
                    state_n   = HDR;
                end
            end
            HDR: begin
                if (out_accept) begin
                    load      = 1'b1;
                    load_data = hdr_vec[(27 - int'(hdr_idx)) * 8 +: 8];
                    if (hdr_idx == 5'd27) state_n = PAY;
                end
            end
            PAY: begin
                s_axis_tready[grant] = out_accept;
                if (in_fire) begin
                    load      = 1'b1;
                    load_data = s_axis_tdata[8*grant +: 8];
                    load_last = byte_is_last;
                    if (byte_is_last) begin
                        trunc_ev = !s_axis_tlast[grant];
                        state_n  = s_axis_tlast[grant] ? GAP : DRAIN;
                    end else if (s_axis_tlast[grant]) begin
                        pad_ev  = 1'b1;
                        state_n = PAD;
                    end
                end
            end
            PAD: begin
                if (out_accept) begin
                    load      = 1'b1;
                    load_last = byte_is_last;
                    if (byte_is_last) state_n = GAP;
                end
            end
            DRAIN: begin
                s_axis_tready[grant] = 1'b1;
                if (s_axis_tvalid[grant] && s_axis_tlast[grant]) state_n = GAP;
            end
            GAP: if (!m_axis_tvalid && gap_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rr_ptr <= '0; grant <= '0; len_q <= '0; dport_q <= '0;
            ip_id <= '0; csum <= '0; cnt <= '0; hdr_idx <= '0; gap_cnt <= '0;
            m_axis_tvalid <= 1'b0; m_axis_tlast <= 1'b0; m_axis_tdata <= '0;
            err_pad <= 1'b0; err_trunc <= 1'b0;
        end else begin
            if (state == IDLE && grant_found) begin
                grant   <= grant_idx;
                len_q   <= clamp_len(s_len[16*grant_idx +: 16]);
                dport_q <= s_dest_port[16*grant_idx +: 16];
                rr_ptr  <= grant_ptr_n;
            end
            if (state == CALC) begin
                csum    <= ~fold2;
                cnt     <= '0;
                hdr_idx <= 5'd1;
            end
            if (state == HDR && load) hdr_idx <= hdr_idx + 5'd1;
            if ((state == PAY || state == PAD) && load) cnt <= cnt + 16'd1;
            if (state == GAP && !m_axis_tvalid)
                gap_cnt <= (state_n == IDLE) ? '0 : gap_cnt + GW'(1);
            if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= load_data;
                m_axis_tlast  <= load_last;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
            if (last_hs) ip_id <= ip_id + 16'd1;
            err_pad   <= pad_ev;
            err_trunc <= trunc_ev;
        end
    end

`ifdef PKT_STATS_EN
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            stat_frames <= '0;
            stat_pad    <= '0;
            stat_trunc  <= '0;
        end else begin
            if (last_hs && stat_frames != '1) stat_frames <= stat_frames + 32'd1;
            if (err_pad && stat_pad != '1) stat_pad <= stat_pad + 16'd1;
            if (err_trunc && stat_trunc != '1) stat_trunc <= stat_trunc + 16'd1;
        end
    end
`endif

endmodule
